// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: 2-FF sync, polarity, debounce, edge/long/repeat strobes.
// Latency: 2 + DB_CYCLES cycles from input edge to btn_level/btn_press; strobes are 1 cycle.
// No backpressure: strobes are fire-and-forget and must be consumed in the cycle they assert.
module btn_conditioner #(
    parameter int              N_CH          = 8,
    parameter int              DB_CYCLES     = 2_000_000,
    parameter int              LONG_CYCLES   = 100_000_000,
    parameter int              REPEAT_CYCLES = 20_000_000,
    parameter logic [N_CH-1:0] INVERT        = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_long,
    output logic [N_CH-1:0] btn_repeat,
    output logic            any_active
);

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int HW  = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam int RW  = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0]  REP_LAST  = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT,
        ST_LATCHED
    } hold_st_e;

    logic [N_CH-1:0] sync1_q, sync1_d;
    logic [N_CH-1:0] sync2_q, sync2_d;
    logic [N_CH-1:0] level_q, level_d;
    logic [N_CH-1:0] press_q, press_d;
    logic [N_CH-1:0] release_q, release_d;
    logic [N_CH-1:0] long_q, long_d;
    logic [N_CH-1:0] repeat_q, repeat_d;
    logic [DBW-1:0]  db_cnt_q [N_CH];
    logic [DBW-1:0]  db_cnt_d [N_CH];
    logic [HW-1:0]   hold_cnt_q [N_CH];
    logic [HW-1:0]   hold_cnt_d [N_CH];
    logic [RW-1:0]   rep_cnt_q [N_CH];
    logic [RW-1:0]   rep_cnt_d [N_CH];
    hold_st_e        st_q [N_CH];
    hold_st_e        st_d [N_CH];

    logic [N_CH-1:0] s;
    logic [N_CH-1:0] upd;

    always_comb begin
        sync1_d   = btn_in;
        sync2_d   = sync1_q;
        s         = sync2_q ^ INVERT;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        repeat_d  = '0;
        upd       = '0;
        for (int i = 0; i < N_CH; i++) begin
            db_cnt_d[i]   = db_cnt_q[i];
            hold_cnt_d[i] = hold_cnt_q[i];
            rep_cnt_d[i]  = rep_cnt_q[i];
            st_d[i]       = st_q[i];

            // Debounce: any matching sample restarts the run of mismatches.
            if (s[i] == level_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                upd[i]       = 1'b1;
                level_d[i]   = s[i];
                db_cnt_d[i]  = '0;
                press_d[i]   = s[i];
                release_d[i] = ~s[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end

            case (st_q[i])
                ST_IDLE: begin
                    if (upd[i] && s[i]) begin
                        st_d[i]       = ST_HOLD;
                        hold_cnt_d[i] = '0;
                        rep_cnt_d[i]  = '0;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q[i] == HOLD_LAST) begin
                        long_d[i]    = 1'b1;
                        rep_cnt_d[i] = '0;
                        st_d[i]      = (REPEAT_CYCLES > 0) ? ST_REPEAT : ST_LATCHED;
                    end else begin
                        hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (rep_cnt_q[i] == REP_LAST) begin
                        repeat_d[i]  = 1'b1;
                        rep_cnt_d[i] = '0;
                    end else begin
                        rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
                    end
                end
                ST_LATCHED: ;
                default: st_d[i] = ST_IDLE;
            endcase

            // A release on the same edge as a threshold suppresses long/repeat.
            if (upd[i] && !s[i]) begin
                st_d[i]       = ST_IDLE;
                hold_cnt_d[i] = '0;
                rep_cnt_d[i]  = '0;
                long_d[i]     = 1'b0;
                repeat_d[i]   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= INVERT;
            sync2_q   <= INVERT;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            repeat_q  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                db_cnt_q[i]   <= '0;
                hold_cnt_q[i] <= '0;
                rep_cnt_q[i]  <= '0;
                st_q[i]       <= ST_IDLE;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            for (int i = 0; i < N_CH; i++) begin
                db_cnt_q[i]   <= db_cnt_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
                rep_cnt_q[i]  <= rep_cnt_d[i];
                st_q[i]       <= st_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_long    = long_q;
    assign btn_repeat  = repeat_q;
    assign any_active  = |level_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: stimulus queues expected strobe events,
// a negedge monitor pops one entry whenever any strobe is seen.
module tb_btn_conditioner;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_in;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] btn_long;
    logic [3:0] btn_repeat;
    logic       any_active;

    btn_conditioner #(
        .N_CH         (4),
        .DB_CYCLES    (8),
        .LONG_CYCLES  (32),
        .REPEAT_CYCLES(10),
        .INVERT       (4'b1000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long),
        .btn_repeat (btn_repeat),
        .any_active (any_active)
    );

    typedef struct {
        int         cyc;
        logic [3:0] p;
        logic [3:0] r;
        logic [3:0] l;
        logic [3:0] rp;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle with any strobe must match the next expected event.
    always @(negedge clk) begin
        if ((btn_press | btn_release | btn_long | btn_repeat) != 4'b0) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe cyc=%0d got p=%b r=%b l=%b rp=%b required none",
                         cyc, btn_press, btn_release, btn_long, btn_repeat);
            end else begin
                ev_t e;
                e = q.pop_front();
                if (e.cyc != cyc || e.p != btn_press || e.r != btn_release ||
                    e.l != btn_long || e.rp != btn_repeat) begin
                    failures++;
                    $display("FAIL strobe_event got cyc=%0d p=%b r=%b l=%b rp=%b required cyc=%0d p=%b r=%b l=%b rp=%b",
                             cyc, btn_press, btn_release, btn_long, btn_repeat,
                             e.cyc, e.p, e.r, e.l, e.rp);
                end
            end
        end
    end

    task automatic push(input int c, input logic [3:0] p, input logic [3:0] r,
                        input logic [3:0] l, input logic [3:0] rp);
        ev_t e;
        e.cyc = c; e.p = p; e.r = r; e.l = l; e.rp = rp;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b required=%b", name, act, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain got=%0d pending events required=0 (next expected cyc=%0d)",
                     name, q.size(), q[0].cyc);
            q.delete();
        end
    endtask

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int r;
        btn_in = 4'b1000;
        rst_n  = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_level",   btn_level,   4'b0);
        check("rst_press",   btn_press,   4'b0);
        check("rst_release", btn_release, 4'b0);
        check("rst_long",    btn_long,    4'b0);
        check("rst_repeat",  btn_repeat,  4'b0);
        check("rst_any",     {3'b0, any_active}, 4'b0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("pol_idle_level", btn_level, 4'b0);
        check("pol_idle_any", {3'b0, any_active}, 4'b0);

        // Clean press, long, repeats; release lands on a repeat threshold.
        c = cyc;
        btn_in[0] = 1'b1;
        push(c + 10, 4'b0001, 4'b0, 4'b0, 4'b0);
        push(c + 42, 4'b0, 4'b0, 4'b0001, 4'b0);
        push(c + 52, 4'b0, 4'b0, 4'b0, 4'b0001);
        push(c + 62, 4'b0, 4'b0, 4'b0, 4'b0001);
        push(c + 72, 4'b0, 4'b0, 4'b0, 4'b0001);
        push(c + 82, 4'b0, 4'b0, 4'b0, 4'b0001);
        push(c + 92, 4'b0, 4'b0001, 4'b0, 4'b0);
        goto(c + 9);
        check("press_latency_level_before", btn_level, 4'b0);
        goto(c + 11);
        check("press_level", btn_level, 4'b0001);
        check("press_any", {3'b0, any_active}, 4'b0001);
        goto(c + 82);
        btn_in[0] = 1'b0;
        drain("long_repeat", 40);
        check("long_release_level", btn_level, 4'b0);

        // 7-sample glitch is rejected.
        btn_in[1] = 1'b1;
        repeat (7) @(negedge clk);
        btn_in[1] = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch7_level", btn_level, 4'b0);

        // 8-sample pulse is accepted.
        c = cyc;
        btn_in[1] = 1'b1;
        push(c + 10, 4'b0010, 4'b0, 4'b0, 4'b0);
        push(c + 18, 4'b0, 4'b0010, 4'b0, 4'b0);
        goto(c + 8);
        btn_in[1] = 1'b0;
        drain("pulse8", 30);

        // Chatter toggling every 5 cycles never settles.
        for (int k = 0; k < 20; k++) begin
            btn_in[1] = ~btn_in[1];
            repeat (5) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check("chatter_level", btn_level, 4'b0);

        // Short hold on ch2: no long strobe.
        c = cyc;
        btn_in[2] = 1'b1;
        push(c + 10, 4'b0100, 4'b0, 4'b0, 4'b0);
        push(c + 30, 4'b0, 4'b0100, 4'b0, 4'b0);
        goto(c + 20);
        btn_in[2] = 1'b0;
        drain("short_hold", 60);

        // Active-low ch3.
        c = cyc;
        btn_in[3] = 1'b0;
        push(c + 10, 4'b1000, 4'b0, 4'b0, 4'b0);
        push(c + 25, 4'b0, 4'b1000, 4'b0, 4'b0);
        goto(c + 11);
        check("pol_level", btn_level, 4'b1000);
        check("pol_any", {3'b0, any_active}, 4'b0001);
        goto(c + 15);
        btn_in[3] = 1'b1;
        drain("polarity", 30);

        // Concurrent press on ch0/ch1, then reset during REPEAT.
        c = cyc;
        btn_in[1:0] = 2'b11;
        push(c + 10, 4'b0011, 4'b0, 4'b0, 4'b0);
        push(c + 42, 4'b0, 4'b0, 4'b0011, 4'b0);
        push(c + 52, 4'b0, 4'b0, 4'b0, 4'b0011);
        goto(c + 55);
        check("conc_level", btn_level, 4'b0011);
        rst_n = 1'b0;
        #1;
        check("midrst_level", btn_level, 4'b0);
        check("midrst_any", {3'b0, any_active}, 4'b0);
        check("midrst_strobes", btn_press | btn_release | btn_long | btn_repeat, 4'b0);
        drain("concurrent", 5);
        repeat (2) @(negedge clk);
        r = cyc;
        rst_n = 1'b1;
        push(r + 10, 4'b0011, 4'b0, 4'b0, 4'b0);
        push(r + 25, 4'b0, 4'b0011, 4'b0, 4'b0);
        goto(r + 15);
        btn_in[1:0] = 2'b00;
        drain("post_reset", 40);
        repeat (20) @(negedge clk);
        check("final_level", btn_level, 4'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Parametrised multi-channel push-button / switch conditioner for the matrix calculator front panel. It synchronises N asynchronous inputs to clk, applies per-channel polarity, and debounces each channel with a consecutive-sample counter. Per channel it produces a stable level, single-cycle press and release strobes, a long-press strobe and an auto-repeat strobe. It sits between the board pins (print, calc, op buttons) and matrix_io_ctrl, and replaces the per-button debouncer instances.

## Interface
- N_CH, 8, number of channels (1..16)
- DB_CYCLES, 2_000_000, consecutive mismatching samples required to accept a new level (20 ms @ 100 MHz); must be ≥1
- LONG_CYCLES, 100_000_000, cycles of debounced-high level before btn_long fires; must be > DB_CYCLES
- REPEAT_CYCLES, 20_000_000, btn_repeat period after btn_long; 0 disables repeat
- INVERT, {N_CH{1'b0}}, per-channel mask; bit=1 treats that input as active-low
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  reset; asynchronous, active-low
- btn_in  in  N_CH  raw asynchronous button/switch inputs
- btn_level  out  N_CH  debounced active-high level
- btn_press  out  N_CH  1-cycle strobe on debounced 0→1
- btn_release  out  N_CH  1-cycle strobe on debounced 1→0
- btn_long  out  N_CH  1-cycle strobe once per hold reaching LONG_CYCLES
- btn_repeat  out  N_CH  1-cycle strobe every REPEAT_CYCLES after btn_long while held
- any_active  out  1  OR of btn_level

## Operation
- Per-channel 2-FF synchroniser on btn_in; the synchroniser resets to INVERT[i], so the post-polarity sample s[i] is 0 during and after reset.
- s[i] = sync2[i] XOR INVERT[i].
- Debounce counter db_cnt[i], width $clog2(DB_CYCLES+1):
  - If s[i] == btn_level[i], db_cnt clears to 0.
  - If s[i] != btn_level[i] and db_cnt == DB_CYCLES-1, btn_level[i] <= s[i] and db_cnt <= 0.
  - Otherwise db_cnt increments.
  - A glitch shorter than DB_CYCLES samples never changes btn_level. Any matching sample restarts the count.
- Edge strobes are registered so they go high in the first cycle the new btn_level is visible: btn_press on a 0→1 update, btn_release on a 1→0 update.
- Hold logic, per channel, with hold_cnt (width $clog2(LONG_CYCLES)) and rep_cnt (width $clog2(REPEAT_CYCLES+1)):
  - IDLE: btn_level=0, counters 0. On press → HOLD.
  - HOLD: hold_cnt increments each cycle btn_level=1. When hold_cnt == LONG_CYCLES-1, fire btn_long. Then go to REPEAT if REPEAT_CYCLES>0, else LATCHED.
  - REPEAT: rep_cnt increments. At REPEAT_CYCLES-1, fire btn_repeat and clear rep_cnt.
  - LATCHED: no further strobes.
  - From any state, a debounced release returns to IDLE and clears both counters. No long/repeat strobe is issued in the release cycle.
- If the release update and a long/repeat threshold fall on the same edge, release wins: btn_release=1 and btn_long/btn_repeat stay 0.
- Channels are fully independent. Simultaneous events on different channels all strobe in the same cycle.
- any_active is a combinational OR of the btn_level registers.

## Timing
- Reset values: btn_level, btn_press, btn_release, btn_long and btn_repeat are all 0, any_active is 0, and all counters are 0. Reset is asynchronous; it takes effect mid-debounce or mid-hold with no strobe emitted.
- Input held active through reset release: btn_press still fires, after the normal latency.
- Press latency: an input edge stable from cycle t gives btn_level=1 and btn_press=1 at cycle t+2+DB_CYCLES (2 synchroniser stages + DB_CYCLES samples). Release latency is identical.
- btn_long fires LONG_CYCLES cycles after btn_press (counting the btn_press cycle as hold cycle 0).
- First btn_repeat fires REPEAT_CYCLES after btn_long, then every REPEAT_CYCLES.
- Every strobe is exactly 1 cycle wide.

## Test plan
Bench parameters: N_CH=4, DB_CYCLES=8, LONG_CYCLES=32, REPEAT_CYCLES=10, INVERT=4'b1000.

- **Clean press:** ch0 held 1 from cycle 0 → btn_level[0] and btn_press[0] rise at cycle 10, and btn_press is 1 cycle wide.
- **Glitch rejection:** ch1 pulse of 7 cycles → no level change and no strobes. A pulse of 8+ cycles → press fires. Toggling every 5 cycles for 100 cycles → no strobes.
- **Long and repeat:** ch0 held 80 cycles after press → btn_long at press+32, btn_repeat at press+42, +52, +62, +72. Release → btn_release at release+10 and no further strobes.
- **Short hold:** ch2 press held 20 cycles → press, then release, with btn_long never asserted.
- **Polarity:** ch3 input driven 0 (active) → btn_level[3]=1 and any_active=1. Input 1 after reset → btn_level[3] stays 0.
- **Reset mid-operation:** assert rst_n=0 during the REPEAT state → all outputs 0 immediately. Deassert with the input still held → btn_press fires 10 cycles later.
- **Concurrency:** ch0 and ch1 pressed on the same cycle → both btn_press strobes in the same cycle.
